servo_channel_scheduler: RTL and testbench

//   Shares one pulse-width timer among NUM_CH servo outputs, RC-PPM style. Within each

---
 rtl/servo_channel_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_servo_channel_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_channel_scheduler.sv
// -----------------------------------------------------------------------------
// servo_channel_scheduler
//   Drives NUM_CH servo pins from one shared pulse-width timer, RC-PPM style.
//   Each FRAME_CYCLES frame fires the enabled channels in ascending order.
//   Each channel gets a pulse of MIN_PULSE + pos*STEP_CYCLES cycles, followed
//   by GAP_CYCLES all-low cycles. Positions are written into a shadow bank at
//   any time. The shadow bank and the enable mask are latched once per frame,
//   so a running frame never changes shape.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   ena          run enable; low clears the frame and forces outputs low
//   pos_wr       shadow position write strobe
//   pos_ch       channel index for the write (indices >= NUM_CH are ignored)
//   pos_data     position 0..255
//   ch_en        channel enable mask, sampled at frame start
//   servo_out    registered pulse outputs (at most one bit high)
//   frame_start  one-cycle pulse at the start of each frame
//   busy         high while any pulse or gap of the frame is in progress
//   active_ch    index of the channel currently pulsing, 0 otherwise
// -----------------------------------------------------------------------------
module servo_channel_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int FRAME_CYCLES = 200000,
    parameter int MIN_PULSE    = 10000,
    parameter int STEP_CYCLES  = 39,
    parameter int GAP_CYCLES   = 100,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int CNT_W       = $clog2(FRAME_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              pos_wr,
    input  logic [CH_W-1:0]   pos_ch,
    input  logic [7:0]        pos_data,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] servo_out,
    output logic              frame_start,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] FC_LAST    = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CH_W:0]    NUM_CH_L   = (CH_W + 1)'(NUM_CH);
    localparam logic [7:0]       POS_CENTER = 8'd128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        WAIT   = 3'd4
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    fc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CH_W-1:0]     last_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [7:0]          shadow_q [NUM_CH];
    logic [7:0]          active_q [NUM_CH];
    logic [NUM_CH-1:0]   servo_q;
    logic                frame_start_q;
    logic                busy_q;
    logic [CH_W-1:0]     active_ch_q;

    logic                sel_found_s;
    logic [CH_W-1:0]     sel_ch_s;
    logic [NUM_CH-1:0]   sel_onehot_s;
    logic [CNT_W-1:0]    sel_len_s;

    // Pulse length minus one, computed at 32 bits before narrowing to the counter.
    function automatic logic [CNT_W-1:0] pulse_last(input logic [7:0] pos);
        logic [31:0] w;
        w = 32'(MIN_PULSE) + 32'(pos) * 32'(STEP_CYCLES) - 32'd1;
        return w[CNT_W-1:0];
    endfunction

    // Next channel: lowest enabled index above the last served one.
    // In SELECT (the first pick of a frame) every enabled channel qualifies.
    always_comb begin
        sel_found_s = 1'b0;
        sel_ch_s    = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sel_found_s = sel_found_s |
                          (mask_q[i] && ((state_q == SELECT) || (CH_W'(i) > last_q)));
            sel_ch_s    = (mask_q[i] && ((state_q == SELECT) || (CH_W'(i) > last_q)))
                          ? CH_W'(i) : sel_ch_s;
        end
        sel_onehot_s = {{(NUM_CH - 1){1'b0}}, 1'b1} << sel_ch_s;
        sel_len_s    = pulse_last(active_q[sel_ch_s]);
    end

    // Shadow position bank, written whether or not the scheduler runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= POS_CENTER;
            end
        end else if (pos_wr && ({1'b0, pos_ch} < NUM_CH_L)) begin
            shadow_q[pos_ch] <= pos_data;
        end
    end

    // Frame counter, per-frame latch and channel sequencing FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fc_q          <= CNT_ZERO;
            cnt_q         <= CNT_ZERO;
            last_q        <= {CH_W{1'b0}};
            mask_q        <= {NUM_CH{1'b0}};
            servo_q       <= {NUM_CH{1'b0}};
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            active_ch_q   <= {CH_W{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= POS_CENTER;
            end
        end else if (!ena) begin
            // Holding fc at 0 makes the first enabled cycle start a frame.
            state_q       <= IDLE;
            fc_q          <= CNT_ZERO;
            cnt_q         <= CNT_ZERO;
            servo_q       <= {NUM_CH{1'b0}};
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            active_ch_q   <= {CH_W{1'b0}};
        end else begin
            fc_q          <= (fc_q == FC_LAST) ? CNT_ZERO : fc_q + CNT_ONE;
            frame_start_q <= (fc_q == CNT_ZERO);
            if (fc_q == CNT_ZERO) begin
                // A write on this same edge lands in shadow_q after the copy.
                for (int i = 0; i < NUM_CH; i++) begin
                    active_q[i] <= shadow_q[i];
                end
                mask_q      <= ch_en;
                state_q     <= SELECT;
                servo_q     <= {NUM_CH{1'b0}};
                busy_q      <= 1'b0;
                active_ch_q <= {CH_W{1'b0}};
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    SELECT: begin
                        if (sel_found_s) begin
                            servo_q     <= sel_onehot_s;
                            busy_q      <= 1'b1;
                            active_ch_q <= sel_ch_s;
                            last_q      <= sel_ch_s;
                            cnt_q       <= sel_len_s;
                            state_q     <= PULSE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                    PULSE: begin
                        if (cnt_q == CNT_ZERO) begin
                            servo_q     <= {NUM_CH{1'b0}};
                            active_ch_q <= {CH_W{1'b0}};
                            cnt_q       <= GAP_LAST;
                            state_q     <= GAP;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    GAP: begin
                        // The next pulse starts straight after the gap's last cycle.
                        if (cnt_q != CNT_ZERO) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (sel_found_s) begin
                            servo_q     <= sel_onehot_s;
                            active_ch_q <= sel_ch_s;
                            last_q      <= sel_ch_s;
                            cnt_q       <= sel_len_s;
                            state_q     <= PULSE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        state_q <= WAIT;
                    end
                    default: begin
                        servo_q <= {NUM_CH{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign active_ch   = active_ch_q;

endmodule

// File: tb/tb_servo_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_channel_scheduler
//   Directed and randomised stimulus for servo_channel_scheduler (4 channels),
//   plus a 3-channel build sharing the same inputs for the invalid-index write.
//   The reference model keeps a frame-level schedule: at each frame latch it
//   lays out every enabled channel's pulse as an absolute cycle interval.
//   Expected outputs for a cycle come from membership in those intervals.
// -----------------------------------------------------------------------------
module tb_servo_channel_scheduler;

    localparam int NCH   = 4;
    localparam int FRAME = 1200;
    localparam int MINP  = 10;
    localparam int STEP  = 1;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       pos_wr;
    logic [1:0] pos_ch;
    logic [7:0] pos_data;
    logic [3:0] ch_en;
    logic [3:0] servo_out;
    logic       frame_start;
    logic       busy;
    logic [1:0] active_ch;
    logic [2:0] servo3;
    logic       fs3;
    logic       busy3;
    logic [1:0] act3;

    servo_channel_scheduler #(
        .NUM_CH(NCH), .FRAME_CYCLES(FRAME), .MIN_PULSE(MINP),
        .STEP_CYCLES(STEP), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .ena(ena), .pos_wr(pos_wr), .pos_ch(pos_ch),
        .pos_data(pos_data), .ch_en(ch_en), .servo_out(servo_out),
        .frame_start(frame_start), .busy(busy), .active_ch(active_ch)
    );

    servo_channel_scheduler #(
        .NUM_CH(3), .FRAME_CYCLES(FRAME), .MIN_PULSE(MINP),
        .STEP_CYCLES(STEP), .GAP_CYCLES(GAP)
    ) dut3 (
        .clk(clk), .reset(reset), .ena(ena), .pos_wr(pos_wr), .pos_ch(pos_ch),
        .pos_data(pos_data), .ch_en(ch_en[2:0]), .servo_out(servo3),
        .frame_start(fs3), .busy(busy3), .active_ch(act3)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    int m_shadow [NCH];
    int m_fc       = 0;
    bit m_valid    = 1'b0;
    int m_T        = 0;
    int m_start [NCH];
    int m_end   [NCH];
    int m_busy_end = 0;

    int hi4 [NCH];
    int hi3 [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output shortly after the edge.
    task automatic tick();
        logic [3:0] e_servo;
        logic       e_busy;
        logic       e_fs;
        logic [1:0] e_act;
        int         t;
        int         w;
        @(posedge clk);
        cyc++;
        if (reset) begin
            for (int c = 0; c < NCH; c++) m_shadow[c] = 128;
            m_fc    = 0;
            m_valid = 1'b0;
        end else begin
            if (!ena) begin
                m_fc    = 0;
                m_valid = 1'b0;
            end else begin
                if (m_fc == 0) begin
                    m_valid    = 1'b1;
                    m_T        = cyc;
                    t          = cyc + 1;
                    m_busy_end = cyc;
                    for (int c = 0; c < NCH; c++) begin
                        if (ch_en[c]) begin
                            w          = MINP + m_shadow[c] * STEP;
                            m_start[c] = t;
                            m_end[c]   = t + w - 1;
                            m_busy_end = m_end[c] + GAP;
                            t          = m_busy_end + 1;
                        end else begin
                            m_start[c] = -1;
                            m_end[c]   = -2;
                        end
                    end
                end
                m_fc = (m_fc + 1) % FRAME;
            end
            if (pos_wr) m_shadow[pos_ch] = int'(pos_data);
        end
        e_servo = 4'd0;
        e_busy  = 1'b0;
        e_fs    = 1'b0;
        e_act   = 2'd0;
        if (m_valid) begin
            e_fs   = (cyc == m_T);
            e_busy = (cyc > m_T) && (cyc <= m_busy_end);
            for (int c = 0; c < NCH; c++) begin
                if (cyc >= m_start[c] && cyc <= m_end[c]) begin
                    e_servo[c] = 1'b1;
                    e_act      = 2'(c);
                end
            end
        end
        #1;
        for (int c = 0; c < NCH; c++) hi4[c] += int'(servo_out[c]);
        for (int c = 0; c < 3; c++) hi3[c] += int'(servo3[c]);
        chk("servo_out",   32'(servo_out),   32'(e_servo));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("active_ch",   32'(active_ch),   32'(e_act));
    endtask

    task automatic wait_frame_start();
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FRAME);
        chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    task automatic wait_model_fc0();
        int n = 0;
        while (m_fc != 0 && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    // Called on a frame_start cycle: counts each channel's high cycles over the frame.
    task automatic count_frame(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
        int exp4 [NCH];
        exp4 = '{e0, e1, e2, e3};
        for (int c = 0; c < NCH; c++) hi4[c] = 0;
        for (int c = 0; c < 3; c++) hi3[c] = 0;
        repeat (FRAME - 1) tick();
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s_width_ch%0d", tag, c), 32'(hi4[c]), 32'(exp4[c]));
        for (int c = 0; c < 3; c++)
            chk($sformatf("%s_n3_width_ch%0d", tag, c), 32'(hi3[c]), 32'(exp4[c]));
    endtask

    task automatic measure_frame(input string tag, input int e0, input int e1,
                                 input int e2, input int e3);
        wait_frame_start();
        count_frame(tag, e0, e1, e2, e3);
    endtask

    task automatic write_pos(input logic [1:0] ch, input logic [7:0] val);
        pos_wr   = 1'b1;
        pos_ch   = ch;
        pos_data = val;
        tick();
        pos_wr   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        ena      = 1'b0;
        pos_wr   = 1'b0;
        pos_ch   = 2'd0;
        pos_data = 8'd0;
        ch_en    = 4'hF;
        for (int c = 0; c < NCH; c++) begin
            m_shadow[c] = 128;
            m_start[c]  = -1;
            m_end[c]    = -2;
            hi4[c]      = 0;
        end
        for (int c = 0; c < 3; c++) hi3[c] = 0;

        // reset state
        repeat (3) tick();
        chk("reset_servo", 32'(servo_out), 32'd0);
        chk("reset_busy",  32'(busy),      32'd0);
        reset = 1'b0;
        ena   = 1'b1;

        // 1: centre positions on all channels
        measure_frame("center", 138, 138, 138, 138);
        measure_frame("center2", 138, 138, 138, 138);

        // 2: extreme and small positions
        repeat (5) tick();
        write_pos(2'd0, 8'd0);
        write_pos(2'd1, 8'd5);
        write_pos(2'd2, 8'd255);
        write_pos(2'd3, 8'd1);
        measure_frame("positions", 10, 15, 265, 11);

        // 3: partial mask, then empty mask
        ch_en = 4'b1010;
        measure_frame("mask1010", 0, 15, 0, 11);
        ch_en = 4'b0000;
        measure_frame("mask0", 0, 0, 0, 0);
        ch_en = 4'hF;

        // 4: write on the latch edge is deferred one frame
        repeat (3) tick();
        wait_model_fc0();
        write_pos(2'd2, 8'd40);
        chk("latch_edge_frame_start", 32'(frame_start), 32'd1);
        count_frame("latch_old", 10, 15, 265, 11);
        tick();
        write_pos(2'd3, 8'd0);   // out of range for the 3-channel build
        measure_frame("latch_new", 10, 15, 50, 10);

        // 5: drop ena in the middle of ch1's pulse, then re-enable
        wait_frame_start();
        repeat (18) tick();
        chk("mid_ch1_servo", 32'(servo_out), 32'd2);
        ena = 1'b0;
        tick();
        chk("ena_drop_servo", 32'(servo_out), 32'd0);
        chk("ena_drop_busy",  32'(busy),      32'd0);
        repeat (20) tick();
        ena = 1'b1;
        tick();
        chk("reena_frame_start", 32'(frame_start), 32'd1);
        count_frame("reena", 10, 15, 50, 10);

        // 6: reset in the middle of a pulse restores centre positions
        repeat (40) tick();
        chk("pre_reset_servo", 32'(servo_out), 32'd4);
        reset = 1'b1;
        tick();
        chk("reset_mid_servo",  32'(servo_out),   32'd0);
        chk("reset_mid_busy",   32'(busy),        32'd0);
        chk("reset_mid_active", 32'(active_ch),   32'd0);
        chk("reset_mid_fs",     32'(frame_start), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        measure_frame("after_reset", 138, 138, 138, 138);

        // randomised writes, masks and brief enable drops
        for (int k = 0; k < 3 * FRAME; k++) begin
            pos_wr   = ($urandom_range(0, 49) == 0);
            pos_ch   = 2'($urandom);
            pos_data = 8'($urandom);
            if ($urandom_range(0, 299) == 0) ch_en = 4'($urandom);
            ena = ($urandom_range(0, 1999) != 0);
            tick();
        end
        pos_wr = 1'b0;
        ena    = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
